mac_tx_framer: RTL and testbench

//  Consumer end of the client MAC TX byte interface (mac_tx_data/dvld/ack) used by frame_sender-class clients.

---
 rtl/mac_tx_framer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mac_tx_framer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_framer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mac_tx_framer
//
// Consumer end of the client MAC TX byte interface. Each client frame is turned
// into a GMII byte stream: 7x 0x55 preamble, 0xD5 SFD, client data, optional
// zero pad to MIN_DATA bytes, optional CRC-32 FCS (LSB byte first), then an
// inter-frame gap. Oversized or truncated frames are aborted with gmii_tx_er.
//
// Optional feature: define TX_STATS_EN to add frame/byte/abort statistics.
//
// Ports
//   tx_clk               transmit clock
//   reset                asynchronous, active-high
//   conf_tx_en           transmitter enable, sampled only when a frame starts
//   conf_tx_jumbo_en     use JUMBO_FRAME instead of MAX_FRAME as the size limit
//   conf_tx_no_gen_crc   client supplies FCS: no pad, no FCS append
//   mac_tx_data[7:0]     client byte
//   mac_tx_dvld          client frame valid, high for the whole frame
//   mac_tx_ack           one-cycle pulse; byte0 is taken at the end of it
//   gmii_txd[7:0]        GMII data
//   gmii_tx_en           GMII enable
//   gmii_tx_er           GMII error, one cycle on frame abort
//   tx_busy              high whenever the framer is not idle
//   stat_frames[31:0]    (TX_STATS_EN) good frames sent
//   stat_bytes[31:0]     (TX_STATS_EN) data+pad+FCS bytes of good frames
//   stat_aborts[15:0]    (TX_STATS_EN) aborted frames
// -----------------------------------------------------------------------------
module mac_tx_framer #(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_DATA    = 60,
    parameter int MAX_FRAME   = 1518,
    parameter int JUMBO_FRAME = 9018
) (
    input  logic        tx_clk,
    input  logic        reset,
    input  logic        conf_tx_en,
    input  logic        conf_tx_jumbo_en,
    input  logic        conf_tx_no_gen_crc,
    input  logic [7:0]  mac_tx_data,
    input  logic        mac_tx_dvld,
    output logic        mac_tx_ack,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        tx_busy
`ifdef TX_STATS_EN
    ,
    output logic [31:0] stat_frames,
    output logic [31:0] stat_bytes,
    output logic [15:0] stat_aborts
`endif
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_PRE   = 4'd1;
    localparam logic [3:0] ST_SFD   = 4'd2;
    localparam logic [3:0] ST_DATA  = 4'd3;
    localparam logic [3:0] ST_PAD   = 4'd4;
    localparam logic [3:0] ST_FCS   = 4'd5;
    localparam logic [3:0] ST_IFG   = 4'd6;
    localparam logic [3:0] ST_ABORT = 4'd7;
    localparam logic [3:0] ST_DROP  = 4'd8;

    localparam int PRE_BYTES = 7;

    logic [3:0]  state, state_n;
    logic [7:0]  phase, phase_n;
    logic [13:0] byte_cnt, byte_cnt_n;
    logic [31:0] crc, crc_n;
    logic        jumbo_q, jumbo_n;
    logic        no_crc_q, no_crc_n;
    logic [7:0]  txd_n;
    logic        tx_en_n, tx_er_n, ack_n;
    logic [14:0] limit, next_len;
    logic        oversize;

    // Reflected IEEE 802.3 CRC-32 update, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // Length the frame would have if the byte on the bus were accepted now;
    // with CRC generation the 4 FCS bytes count against the limit as well.
    assign limit    = jumbo_q ? 15'(JUMBO_FRAME) : 15'(MAX_FRAME);
    assign next_len = {1'b0, byte_cnt} + 15'd1 + (no_crc_q ? 15'd0 : 15'd4);
    assign oversize = next_len > limit;

    // Next-state logic. Outputs are registered, so every branch produces the
    // output values of the cycle it is entering.
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        byte_cnt_n = byte_cnt;
        crc_n      = crc;
        jumbo_n    = jumbo_q;
        no_crc_n   = no_crc_q;
        txd_n      = 8'h00;
        tx_en_n    = 1'b0;
        tx_er_n    = 1'b0;
        ack_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mac_tx_dvld && conf_tx_en) begin
                    state_n    = ST_PRE;
                    phase_n    = 8'd1;
                    txd_n      = 8'h55;
                    tx_en_n    = 1'b1;
                    byte_cnt_n = '0;
                    crc_n      = '1;
                    jumbo_n    = conf_tx_jumbo_en;
                    no_crc_n   = conf_tx_no_gen_crc;
                end
            end
            ST_PRE: begin
                if (!mac_tx_dvld) begin
                    state_n = ST_ABORT;
                    tx_en_n = 1'b1;
                    tx_er_n = 1'b1;
                end else if (phase < 8'(PRE_BYTES)) begin
                    phase_n = phase + 8'd1;
                    txd_n   = 8'h55;
                    tx_en_n = 1'b1;
                end else begin
                    state_n = ST_SFD;
                    txd_n   = 8'hD5;
                    tx_en_n = 1'b1;
                    ack_n   = 1'b1;
                end
            end
            // SFD shares the byte-accept path: byte0 is taken at the ack edge.
            ST_SFD, ST_DATA: begin
                if (!mac_tx_dvld) begin
                    if (state == ST_SFD) begin
                        state_n = ST_ABORT;
                        tx_en_n = 1'b1;
                        tx_er_n = 1'b1;
                    end else if (!no_crc_q && byte_cnt < 14'(MIN_DATA)) begin
                        state_n    = ST_PAD;
                        tx_en_n    = 1'b1;
                        byte_cnt_n = byte_cnt + 14'd1;
                        crc_n      = crc32_byte(crc, 8'h00);
                    end else if (!no_crc_q) begin
                        state_n    = ST_FCS;
                        txd_n      = ~crc[7:0];
                        tx_en_n    = 1'b1;
                        phase_n    = 8'd1;
                        byte_cnt_n = byte_cnt + 14'd4;
                    end else begin
                        state_n = ST_IFG;
                        phase_n = 8'd1;
                    end
                end else if (oversize) begin
                    state_n = ST_ABORT;
                    tx_en_n = 1'b1;
                    tx_er_n = 1'b1;
                end else begin
                    state_n    = ST_DATA;
                    txd_n      = mac_tx_data;
                    tx_en_n    = 1'b1;
                    byte_cnt_n = byte_cnt + 14'd1;
                    crc_n      = crc32_byte(crc, mac_tx_data);
                end
            end
            ST_PAD: begin
                if (byte_cnt < 14'(MIN_DATA)) begin
                    tx_en_n    = 1'b1;
                    byte_cnt_n = byte_cnt + 14'd1;
                    crc_n      = crc32_byte(crc, 8'h00);
                end else begin
                    state_n    = ST_FCS;
                    txd_n      = ~crc[7:0];
                    tx_en_n    = 1'b1;
                    phase_n    = 8'd1;
                    byte_cnt_n = byte_cnt + 14'd4;
                end
            end
            ST_FCS: begin
                if (phase < 8'd4) begin
                    txd_n   = ~crc[{phase[1:0], 3'b000} +: 8];
                    tx_en_n = 1'b1;
                    phase_n = phase + 8'd1;
                end else begin
                    state_n = ST_IFG;
                    phase_n = 8'd1;
                end
            end
            // The mandatory IDLE cycle that follows is part of the gap, so
            // the IFG state itself lasts one cycle less than IFG_BYTES.
            ST_IFG: begin
                if (phase < 8'(IFG_BYTES - 1))
                    phase_n = phase + 8'd1;
                else
                    state_n = ST_IDLE;
            end
            ST_ABORT: begin
                if (mac_tx_dvld) begin
                    state_n = ST_DROP;
                end else begin
                    state_n = ST_IFG;
                    phase_n = 8'd1;
                end
            end
            ST_DROP: begin
                if (!mac_tx_dvld) begin
                    state_n = ST_IFG;
                    phase_n = 8'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            phase      <= '0;
            byte_cnt   <= '0;
            crc        <= '0;
            jumbo_q    <= 1'b0;
            no_crc_q   <= 1'b0;
            gmii_txd   <= '0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            mac_tx_ack <= 1'b0;
            tx_busy    <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            byte_cnt   <= byte_cnt_n;
            crc        <= crc_n;
            jumbo_q    <= jumbo_n;
            no_crc_q   <= no_crc_n;
            gmii_txd   <= txd_n;
            gmii_tx_en <= tx_en_n;
            gmii_tx_er <= tx_er_n;
            mac_tx_ack <= ack_n;
            tx_busy    <= (state_n != ST_IDLE);
        end
    end

`ifdef TX_STATS_EN
    logic good_end, abort_entry;

    // A good frame ends on FCS entry, or on DATA->IFG when the client owns the FCS.
    // byte_cnt_n already includes the 4 FCS bytes on FCS entry.
    assign good_end    = (state_n == ST_FCS && state != ST_FCS) ||
                         (state == ST_DATA && state_n == ST_IFG);
    assign abort_entry = (state_n == ST_ABORT) && (state != ST_ABORT);

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            stat_frames <= '0;
            stat_bytes  <= '0;
            stat_aborts <= '0;
        end else begin
            if (good_end) begin
                stat_frames <= stat_frames + 32'd1;
                stat_bytes  <= stat_bytes + 32'(byte_cnt_n);
            end
            if (abort_entry)
                stat_aborts <= stat_aborts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_tx_framer.sv
`timescale 1ns/1ps
module tb_mac_tx_framer;

    logic        tx_clk = 1'b0;
    logic        reset = 1'b1;
    logic        conf_tx_en = 1'b0;
    logic        conf_tx_jumbo_en = 1'b0;
    logic        conf_tx_no_gen_crc = 1'b0;
    logic [7:0]  mac_tx_data = 8'h00;
    logic        mac_tx_dvld = 1'b0;
    logic        mac_tx_ack;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en, gmii_tx_er, tx_busy;
`ifdef TX_STATS_EN
    logic [31:0] stat_frames, stat_bytes;
    logic [15:0] stat_aborts;
`endif

    mac_tx_framer dut (
        .tx_clk(tx_clk),
        .reset(reset),
        .conf_tx_en(conf_tx_en),
        .conf_tx_jumbo_en(conf_tx_jumbo_en),
        .conf_tx_no_gen_crc(conf_tx_no_gen_crc),
        .mac_tx_data(mac_tx_data),
        .mac_tx_dvld(mac_tx_dvld),
        .mac_tx_ack(mac_tx_ack),
        .gmii_txd(gmii_txd),
        .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er),
        .tx_busy(tx_busy)
`ifdef TX_STATS_EN
        ,
        .stat_frames(stat_frames),
        .stat_bytes(stat_bytes),
        .stat_aborts(stat_aborts)
`endif
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        int len;
        bit no_crc;
        bit jumbo;
        int pat;
        int exp_en;
        int exp_er;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          logging = 1'b0;
    logic        ack_seen = 1'b0;
    logic        q_en[$], q_er[$], q_ack[$];
    logic [7:0]  q_txd[$];
    logic [7:0]  data_q[$];
    logic [8:0]  exp_q[$];
    longint      exp_frames = 0, exp_bytes = 0, exp_aborts = 0;

    always @(negedge tx_clk) begin
        ack_seen = mac_tx_ack;
        if (logging) begin
            q_en.push_back(gmii_tx_en);
            q_er.push_back(gmii_tx_er);
            q_ack.push_back(mac_tx_ack);
            q_txd.push_back(gmii_txd);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Bit-serial CRC-32 over a whole message, written from the polynomial definition.
    function automatic logic [31:0] ref_crc(input logic [7:0] m[$]);
        logic [31:0] r = 32'hFFFF_FFFF;
        foreach (m[i]) begin
            for (int b = 0; b < 8; b++) begin
                logic fb;
                fb = r[0] ^ m[i][b];
                r  = {1'b0, r[31:1]};
                if (fb) r = r ^ 32'hEDB8_8320;
            end
        end
        return r;
    endfunction

    task automatic make_data(input int len, input int pat);
        data_q = {};
        for (int i = 0; i < len; i++) begin
            case (pat)
                0:       data_q.push_back(8'(i));
                1:       data_q.push_back(8'(8'h31 + (i % 9)));
                default: data_q.push_back(8'($urandom));
            endcase
        end
    endtask

    // Expected tx_en-high stream as {tx_er, txd}, plus statistics bookkeeping.
    task automatic build_expected(input bit no_crc, input bit jumbo);
        int limit = jumbo ? 9018 : 1518;
        int ovh   = no_crc ? 0 : 4;
        int len   = data_q.size();
        logic [7:0]  body[$];
        logic [31:0] fcs;
        exp_q = {};
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        if (len + ovh > limit) begin
            for (int i = 0; i < limit - ovh; i++) exp_q.push_back({1'b0, data_q[i]});
            exp_q.push_back({1'b1, 8'h00});
            exp_aborts++;
        end else begin
            body = data_q;
            if (!no_crc) while (body.size() < 60) body.push_back(8'h00);
            foreach (body[i]) exp_q.push_back({1'b0, body[i]});
            if (!no_crc) begin
                fcs = ~ref_crc(body);
                for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, fcs[8*k +: 8]});
            end
            exp_frames++;
            exp_bytes += body.size() + ovh;
        end
    endtask

    task automatic clear_log();
        q_en.delete(); q_er.delete(); q_ack.delete(); q_txd.delete();
    endtask

    // Client side: hold byte0 until ack, then one new byte per edge.
    task automatic drive_frame();
        int  len = data_q.size();
        int  idx = 0;
        int  guard = 0;
        bit  started = 1'b0;
        @(posedge tx_clk); #1;
        mac_tx_dvld = 1'b1;
        mac_tx_data = data_q[0];
        while (idx < len) begin
            @(posedge tx_clk);
            if (started) idx++;
            else if (ack_seen === 1'b1) begin started = 1'b1; idx = 1; end
            else begin
                guard++;
                if (guard > 200) begin
                    n_checks++; n_errors++;
                    $display("FAIL ack_timeout: got no ack within 200 cycles");
                    idx = len;
                end
            end
            #1;
            if (idx < len) mac_tx_data = data_q[idx];
            else begin mac_tx_dvld = 1'b0; mac_tx_data = 8'h00; end
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (tx_busy !== 1'b0 && t < 300) begin @(negedge tx_clk); t++; end
        check({name, " idle"}, tx_busy, 0);
        repeat (2) @(negedge tx_clk);
    endtask

    task automatic check_log(input string name, input int exp_acks);
        logic [8:0] got[$];
        int acks = 0, bad = 0, first = -1;
        foreach (q_en[i]) begin
            if (q_en[i] === 1'b1 || q_er[i] === 1'b1) got.push_back({q_er[i], q_txd[i]});
            if (q_ack[i] === 1'b1) acks++;
        end
        check({name, " en_cycles"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        if (first >= 0) $display("  %s: first differing stream position %0d", name, first);
        check({name, " bytes_wrong"}, bad, 0);
        check({name, " acks"}, acks, exp_acks);
    endtask

    task automatic run_frame(input string name, input int len, input bit no_crc, input bit jumbo,
                             input int pat, output int en_cnt, output int er_cnt);
        make_data(len, pat);
        conf_tx_no_gen_crc = no_crc;
        conf_tx_jumbo_en   = jumbo;
        build_expected(no_crc, jumbo);
        clear_log();
        logging = 1'b1;
        drive_frame();
        wait_idle(name);
        logging = 1'b0;
        check_log(name, 1);
        en_cnt = 0;
        er_cnt = 0;
        foreach (q_en[i]) begin
            if (q_en[i] === 1'b1) en_cnt++;
            if (q_er[i] === 1'b1) er_cnt++;
        end
    endtask

    task automatic check_stats(input string name);
`ifdef TX_STATS_EN
        check({name, " stat_frames"}, stat_frames, exp_frames[31:0]);
        check({name, " stat_bytes"}, stat_bytes, exp_bytes[31:0]);
        check({name, " stat_aborts"}, stat_aborts, exp_aborts[15:0]);
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    initial begin
        vec_t vecs[11];
        int   en_cnt, er_cnt, t, f, r;

        vecs[0]  = '{64,   1'b0, 1'b0, 0, 76,   0};
        vecs[1]  = '{9,    1'b0, 1'b0, 1, 72,   0};
        vecs[2]  = '{20,   1'b1, 1'b0, 0, 28,   0};
        vecs[3]  = '{1600, 1'b0, 1'b0, 0, 1523, 1};
        vecs[4]  = '{1600, 1'b0, 1'b1, 0, 1612, 0};
        vecs[5]  = '{1,    1'b0, 1'b0, 2, 72,   0};
        vecs[6]  = '{60,   1'b0, 1'b0, 2, 72,   0};
        vecs[7]  = '{1514, 1'b0, 1'b0, 0, 1526, 0};
        vecs[8]  = '{1515, 1'b0, 1'b0, 0, 1523, 1};
        vecs[9]  = '{1519, 1'b1, 1'b0, 0, 1527, 1};
        vecs[10] = '{1518, 1'b1, 1'b0, 0, 1526, 0};

        // Reset state
        repeat (3) @(negedge tx_clk);
        check("reset ack", mac_tx_ack, 0);
        check("reset txd", gmii_txd, 0);
        check("reset tx_en", gmii_tx_en, 0);
        check("reset tx_er", gmii_tx_er, 0);
        check("reset busy", tx_busy, 0);
        check_stats("reset");
        #2 reset = 1'b0;
        conf_tx_en = 1'b1;
        repeat (2) @(negedge tx_clk);

        // Directed table
        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_frame(nm, vecs[i].len, vecs[i].no_crc, vecs[i].jumbo, vecs[i].pat, en_cnt, er_cnt);
            check({nm, " table_en"}, en_cnt, vecs[i].exp_en);
            check({nm, " table_er"}, er_cnt, vecs[i].exp_er);
        end

        // Randomized frames against the model
        for (int i = 0; i < 8; i++)
            run_frame($sformatf("rand%0d", i), $urandom_range(1, 130), 1'($urandom_range(0, 1)),
                      1'b0, 2, en_cnt, er_cnt);
        check_stats("after_random");

        // Back-to-back: dvld low for exactly one cycle between frames
        conf_tx_no_gen_crc = 1'b0;
        conf_tx_jumbo_en   = 1'b0;
        clear_log();
        logging = 1'b1;
        make_data(10, 0);
        build_expected(1'b0, 1'b0);
        drive_frame();
        make_data(70, 2);
        build_expected(1'b0, 1'b0);
        drive_frame();
        wait_idle("b2b");
        logging = 1'b0;
        f = -1; r = -1; t = 0;
        for (int i = 1; i < q_en.size(); i++) begin
            if (f < 0 && q_en[i-1] === 1'b1 && q_en[i] === 1'b0) f = i;
            else if (f >= 0 && r < 0 && q_en[i-1] === 1'b0 && q_en[i] === 1'b1) r = i;
        end
        foreach (q_ack[i]) if (q_ack[i] === 1'b1) t++;
        check("b2b gap", r - f, 12);
        check("b2b next_preamble", (r >= 0) ? q_txd[r] : 8'hxx, 8'h55);
        check("b2b acks", t, 2);

        // Client drops dvld during the preamble
        clear_log();
        logging = 1'b1;
        @(posedge tx_clk); #1 mac_tx_dvld = 1'b1;
        repeat (3) @(posedge tx_clk);
        #1 mac_tx_dvld = 1'b0;
        wait_idle("pre_drop");
        logging = 1'b0;
        exp_aborts++;
        en_cnt = 0; er_cnt = 0; t = 0;
        foreach (q_en[i]) begin
            if (q_en[i] === 1'b1) en_cnt++;
            if (q_er[i] === 1'b1) er_cnt++;
            if (q_ack[i] === 1'b1) t++;
        end
        check("pre_drop acks", t, 0);
        check("pre_drop er_cycles", er_cnt, 1);
        check("pre_drop en_cycles", en_cnt, 4);
        check_stats("pre_drop");

        // Transmitter disabled: frame refused
        conf_tx_en = 1'b0;
        clear_log();
        logging = 1'b1;
        @(posedge tx_clk); #1 mac_tx_dvld = 1'b1;
        repeat (20) @(posedge tx_clk);
        #1 mac_tx_dvld = 1'b0;
        repeat (2) @(negedge tx_clk);
        logging = 1'b0;
        en_cnt = 0; t = 0;
        foreach (q_en[i]) begin
            if (q_en[i] !== 1'b0) en_cnt++;
            if (q_ack[i] !== 1'b0) t++;
        end
        check("disabled en_cycles", en_cnt, 0);
        check("disabled acks", t, 0);
        conf_tx_en = 1'b1;

        // Reset during byte 30
        make_data(64, 0);
        @(posedge tx_clk); #1;
        mac_tx_dvld = 1'b1;
        mac_tx_data = data_q[0];
        t = 0;
        while (mac_tx_ack !== 1'b1 && t < 50) begin @(negedge tx_clk); t++; end
        check("rst_mid ack", mac_tx_ack, 1);
        for (int i = 1; i <= 30; i++) begin
            @(posedge tx_clk); #1;
            mac_tx_data = data_q[i];
        end
        check("rst_mid byte30", gmii_txd, data_q[29]);
        #2 reset = 1'b1;
        #1;
        check("rst_mid txd", gmii_txd, 0);
        check("rst_mid tx_en", gmii_tx_en, 0);
        check("rst_mid tx_er", gmii_tx_er, 0);
        check("rst_mid busy", tx_busy, 0);
        check("rst_mid ack_low", mac_tx_ack, 0);
        mac_tx_dvld = 1'b0;
        mac_tx_data = 8'h00;
        #3 reset = 1'b0;
        exp_frames = 0; exp_bytes = 0; exp_aborts = 0;
        check_stats("post_reset");
        repeat (3) @(negedge tx_clk);
        run_frame("post_reset_frame", 64, 1'b0, 1'b0, 2, en_cnt, er_cnt);
        check_stats("post_reset_frame");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
